qed_inst_legalizer: RTL and testbench
=====================================

Name: qed_inst_legalizer

Overview:
- Parametrised, stateful successor to the SQED instruction-constraint logic.
- Classifies each issued RV32I instruction and checks it against the original-half register partition and the memory-window limits.
- Gates stores and the issue budget on a phase FSM driven by sif_commit. Produces a combinational legal flag for formal assumes, plus sticky diagnostics for simulation.
- Sits between the symbolic instruction source and the QED module in design_top.

Parameters:
REG_SPLIT, 16, registers with index < REG_SPLIT are legal in original instructions; power of two, 2..16
LOAD_IMM_LIMIT, 64, load imm12 must be < this value (unsigned)
STORE_IMM_LIMIT, 2, store imm7 (inst[31:25]) must be < this value
MAX_PRE_ISSUE, 8, maximum non-NOP instructions accepted before sif_commit
ALLOW_PC_DEP, 0, 1 permits JAL/AUIPC with any rd < REG_SPLIT; 0 forces rd == 0
CNT_W, 4, issue counter width; must satisfy 2^CNT_W > MAX_PRE_ISSUE

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction presented this cycle
instruction  in  32  RV32I instruction word
sif_commit  in  1  from design_top.dut.sif_commit
legal  out  1  combinational: instruction legal in the current phase (forced 1 when instr_valid=0)
inst_class  out  4  combinational class index: NONE,R,I,LOAD,STORE,BRANCH,JAL,LUI,AUIPC,SYSTEM,NOP
phase  out  2  FSM state
issue_cnt  out  CNT_W  non-NOP instructions accepted in PRE_TC, saturating
violation  out  1  sticky: an illegal instruction was presented while valid
viol_instr  out  32  first illegal instruction word captured

Behaviour:
- Reset (async, rst=1): phase=IDLE, issue_cnt=0, violation=0, viol_instr=0. legal/inst_class remain combinational.
- Decode fields per RV32I: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25], imm12[31:20].
- Format legality:
  - R: rs1, rs2, rd < REG_SPLIT; funct7 0000000 for all ops, or 0100000 for SUB/SRA.
  - I-ALU: rs1, rd < REG_SPLIT; SLLI/SRLI need funct7=0; SRAI needs 0100000.
  - LOAD: funct3 in {000,001,010,100,101}; rs1==0; rd < REG_SPLIT; inst[31:30]==0; imm12 < LOAD_IMM_LIMIT.
  - STORE: funct3 in {000,001,010}; rs1==0; rs2 < REG_SPLIT; inst[31:30]==0; imm7 < STORE_IMM_LIMIT.
  - BRANCH: funct3 not in {010,011}; rs1, rs2 < REG_SPLIT.
  - JAL/AUIPC: rd per ALLOW_PC_DEP. LUI: rd < REG_SPLIT.
  - SYSTEM: only ECALL/EBREAK exact encodings.
  - NOP: opcode 1111111.
- Unrecognised opcode, or recognised opcode with a bad field: inst_class=NONE, legal=0.
- FSM, transitions on posedge clk:
  - IDLE: entered on reset. Goes to PRE_TC on first instr_valid, or to POST_TC if sif_commit=1 that cycle.
  - PRE_TC: STORE illegal. Once issue_cnt == MAX_PRE_ISSUE, only NOP is legal. Goes to POST_TC when sif_commit=1.
  - POST_TC: all formats legal; issue budget not applied. Terminal until reset; sif_commit deassertion is ignored.
  - Phase evaluation for legal uses the registered phase. An instruction in the same cycle as the first sif_commit is judged as PRE_TC.
- issue_cnt: increments when instr_valid && legal && class!=NOP && phase in {IDLE,PRE_TC}. Saturates at MAX_PRE_ISSUE; holds in POST_TC.
- Violation capture: when instr_valid && !legal && !violation, set violation=1 and latch viol_instr the next cycle. Later violations do not overwrite. Illegal instructions do not increment issue_cnt.
- Latency: legal/inst_class 0 cycles; phase, issue_cnt, violation 1 cycle.
- Formal wrapper (outside this block): assume property (@(posedge clk) legal).

Decomposition:
- Package qed_pkg:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC, OP_SYSTEM, OP_NOP);
  - funct7 constants;
  - inst_class_e enum (4-bit);
  - qed_phase_e enum (IDLE, PRE_TC, POST_TC).
- One sub-module, qed_inst_decode: purely combinational field decode plus format legality, parametrised by REG_SPLIT, LOAD_IMM_LIMIT, STORE_IMM_LIMIT, ALLOW_PC_DEP. Outputs inst_class and fmt_ok.
- The top holds the FSM, counter, violation capture and phase gating.

Test Plan:
1. Reset, then ADD x1,x2,x3 (0x003100B3) valid in IDLE -> legal=1, inst_class=R; next cycle phase=PRE_TC, issue_cnt=1.
2. PRE_TC, SW x2,4(x0) (0x00202223) -> legal=0, violation=1 and viol_instr=0x00202223 next cycle. Assert sif_commit, then reissue the same word -> legal=1 in POST_TC.
3. ADD x17,x2,x3 (0x003108B3) -> legal=0. LW x1,64(x0) (0x04002083) -> legal=0. LW x1,60(x0) (0x03C02083) -> legal=1.
4. MAX_PRE_ISSUE=8: issue 8 legal ADDIs, then ADDI -> legal=0 and issue_cnt stays 8; NOP (0x0000007F) -> legal=1.
5. sif_commit=1 in the same cycle as an SW -> legal=0 (judged PRE_TC); the following cycle SW -> legal=1. Dropping sif_commit leaves phase=POST_TC.
6. Assert rst mid-PRE_TC with violation=1 -> phase=IDLE, issue_cnt=0, violation=0 immediately (async); JAL x1 with ALLOW_PC_DEP=0 -> legal=0.

Source files
------------

// File: rtl/qed_pkg.sv
// Shared encodings for the SQED instruction legalizer: RV32I opcodes,
// funct7 values, instruction classes and the commit-phase states.
package qed_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_NOP    = 7'b1111111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_R      = 4'd1,
        CLS_I      = 4'd2,
        CLS_LOAD   = 4'd3,
        CLS_STORE  = 4'd4,
        CLS_BRANCH = 4'd5,
        CLS_JAL    = 4'd6,
        CLS_LUI    = 4'd7,
        CLS_AUIPC  = 4'd8,
        CLS_SYSTEM = 4'd9,
        CLS_NOP    = 4'd10
    } inst_class_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRE_TC  = 2'd1,
        POST_TC = 2'd2
    } qed_phase_e;

endpackage

// File: rtl/qed_inst_decode.sv
// Combinational RV32I field decode and format legality against the
// original-half register partition and the memory-window limits.
module qed_inst_decode
    import qed_pkg::*;
#(
    parameter int unsigned REG_SPLIT       = 16,
    parameter int unsigned LOAD_IMM_LIMIT  = 64,
    parameter int unsigned STORE_IMM_LIMIT = 2,
    parameter int unsigned ALLOW_PC_DEP    = 0
) (
    input  logic [31:0] instruction,
    output inst_class_e inst_class,
    output logic        fmt_ok
);

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [11:0] imm12;
    inst_class_e cls;
    logic        ok;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];
    assign imm12  = instruction[31:20];

    function automatic logic reg_ok(input logic [4:0] r);
        return {27'b0, r} < REG_SPLIT;
    endfunction

    function automatic logic pc_dep_ok(input logic [4:0] r);
        return (ALLOW_PC_DEP != 0) ? reg_ok(r) : (r == 5'd0);
    endfunction

    always_comb begin
        cls = CLS_NONE;
        ok  = 1'b0;
        case (opcode)
            OP_R: begin
                cls = CLS_R;
                ok  = reg_ok(rs1) && reg_ok(rs2) && reg_ok(rd) &&
                      (funct7 == F7_BASE ||
                       (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OP_I: begin
                cls = CLS_I;
                ok  = reg_ok(rs1) && reg_ok(rd);
                // Only the shift-immediates constrain the upper immediate bits
                if (funct3 == 3'b001)
                    ok = ok && (funct7 == F7_BASE);
                else if (funct3 == 3'b101)
                    ok = ok && (funct7 == F7_BASE || funct7 == F7_ALT);
            end
            OP_LOAD: begin
                cls = CLS_LOAD;
                ok  = (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) &&
                      rs1 == 5'd0 && reg_ok(rd) && instruction[31:30] == 2'b00 &&
                      {20'b0, imm12} < LOAD_IMM_LIMIT;
            end
            OP_STORE: begin
                cls = CLS_STORE;
                ok  = funct3 <= 3'b010 && rs1 == 5'd0 && reg_ok(rs2) &&
                      instruction[31:30] == 2'b00 && {25'b0, funct7} < STORE_IMM_LIMIT;
            end
            OP_BRANCH: begin
                cls = CLS_BRANCH;
                ok  = funct3 != 3'b010 && funct3 != 3'b011 && reg_ok(rs1) && reg_ok(rs2);
            end
            OP_JAL: begin
                cls = CLS_JAL;
                ok  = pc_dep_ok(rd);
            end
            OP_AUIPC: begin
                cls = CLS_AUIPC;
                ok  = pc_dep_ok(rd);
            end
            OP_LUI: begin
                cls = CLS_LUI;
                ok  = reg_ok(rd);
            end
            OP_SYSTEM: begin
                cls = CLS_SYSTEM;
                ok  = instruction == INST_ECALL || instruction == INST_EBREAK;
            end
            OP_NOP: begin
                cls = CLS_NOP;
                ok  = 1'b1;
            end
            default: begin
                cls = CLS_NONE;
                ok  = 1'b0;
            end
        endcase
        inst_class = ok ? cls : CLS_NONE;
        fmt_ok     = ok;
    end

endmodule

// File: rtl/qed_inst_legalizer.sv
// SQED instruction legalizer: format legality gated by a commit-phase FSM,
// a saturating pre-commit issue budget, and sticky violation capture.
module qed_inst_legalizer
    import qed_pkg::*;
#(
    parameter int unsigned REG_SPLIT       = 16,
    parameter int unsigned LOAD_IMM_LIMIT  = 64,
    parameter int unsigned STORE_IMM_LIMIT = 2,
    parameter int unsigned MAX_PRE_ISSUE   = 8,
    parameter int unsigned ALLOW_PC_DEP    = 0,
    parameter int unsigned CNT_W           = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [31:0]      instruction,
    input  logic             sif_commit,
    output logic             legal,
    output logic [3:0]       inst_class,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] issue_cnt,
    output logic             violation,
    output logic [31:0]      viol_instr
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PRE_ISSUE);

    qed_phase_e       phase_q;
    logic [CNT_W-1:0] cnt_q;
    inst_class_e      cls;
    logic             fmt_ok;
    logic             phase_ok;
    logic             accept;

    qed_inst_decode #(
        .REG_SPLIT       (REG_SPLIT),
        .LOAD_IMM_LIMIT  (LOAD_IMM_LIMIT),
        .STORE_IMM_LIMIT (STORE_IMM_LIMIT),
        .ALLOW_PC_DEP    (ALLOW_PC_DEP)
    ) u_decode (
        .instruction (instruction),
        .inst_class  (cls),
        .fmt_ok      (fmt_ok)
    );

    // IDLE is gated like PRE_TC: nothing has committed yet in either state
    always_comb begin
        phase_ok = 1'b1;
        if (phase_q != POST_TC) begin
            if (cls == CLS_STORE)
                phase_ok = 1'b0;
            else if (cnt_q == CNT_MAX && cls != CLS_NOP)
                phase_ok = 1'b0;
        end
    end

    assign legal  = !instr_valid || (fmt_ok && phase_ok);
    assign accept = instr_valid && legal && cls != CLS_NOP &&
                    phase_q != POST_TC && cnt_q != CNT_MAX;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= IDLE;
            cnt_q      <= '0;
            violation  <= 1'b0;
            viol_instr <= '0;
        end else begin
            case (phase_q)
                IDLE: begin
                    if (sif_commit)
                        phase_q <= POST_TC;
                    else if (instr_valid)
                        phase_q <= PRE_TC;
                end
                PRE_TC: begin
                    if (sif_commit)
                        phase_q <= POST_TC;
                end
                POST_TC: phase_q <= POST_TC;
                default: phase_q <= IDLE;
            endcase
            if (accept)
                cnt_q <= cnt_q + 1'b1;
            if (instr_valid && !legal && !violation) begin
                violation  <= 1'b1;
                viol_instr <= instruction;
            end
        end
    end

    assign phase      = phase_q;
    assign issue_cnt  = cnt_q;
    assign inst_class = cls;

endmodule

// File: tb/tb_qed_inst_legalizer.sv
// Randomised bench for qed_inst_legalizer against a behavioural reference
// model of the legality rules and the commit-phase bookkeeping.
module tb_qed_inst_legalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        sif_commit;
    logic        legal;
    logic [3:0]  inst_class;
    logic [1:0]  phase;
    logic [3:0]  issue_cnt;
    logic        violation;
    logic [31:0] viol_instr;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // reference state: 0 idle, 1 before commit, 2 after commit
    int unsigned m_ph;
    int unsigned m_cnt;
    bit          m_viol;
    logic [31:0] m_vw;
    logic        obs_legal;

    qed_inst_legalizer #(
        .REG_SPLIT       (16),
        .LOAD_IMM_LIMIT  (64),
        .STORE_IMM_LIMIT (2),
        .MAX_PRE_ISSUE   (8),
        .ALLOW_PC_DEP    (0),
        .CNT_W           (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .sif_commit  (sif_commit),
        .legal       (legal),
        .inst_class  (inst_class),
        .phase       (phase),
        .issue_cnt   (issue_cnt),
        .violation   (violation),
        .viol_instr  (viol_instr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Class index per RV32I field rules: 0 none,1 R,2 I,3 load,4 store,5 branch,
    // 6 jal,7 lui,8 auipc,9 system,10 nop
    function automatic logic [31:0] ref_class(input logic [31:0] w);
        logic [6:0]  opc;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        opc = w[6:0]; rd = w[11:7]; f3 = w[14:12]; rs1 = w[19:15];
        rs2 = w[24:20]; f7 = w[31:25]; imm = w[31:20];
        case (opc)
            7'h33: if (rs1 < 5'd16 && rs2 < 5'd16 && rd < 5'd16 &&
                       (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) return 1;
            7'h13: if (rs1 < 5'd16 && rd < 5'd16) begin
                       if (f3 == 3'd1) return (f7 == 7'h00) ? 2 : 0;
                       if (f3 == 3'd5) return (f7 == 7'h00 || f7 == 7'h20) ? 2 : 0;
                       return 2;
                   end
            7'h03: if ((f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5) &&
                       rs1 == 5'd0 && rd < 5'd16 && w[31:30] == 2'b00 && imm < 12'd64) return 3;
            7'h23: if (f3 <= 3'd2 && rs1 == 5'd0 && rs2 < 5'd16 && w[31:30] == 2'b00 &&
                       f7 < 7'd2) return 4;
            7'h63: if (f3 != 3'd2 && f3 != 3'd3 && rs1 < 5'd16 && rs2 < 5'd16) return 5;
            7'h6F: if (rd == 5'd0) return 6;
            7'h37: if (rd < 5'd16) return 7;
            7'h17: if (rd == 5'd0) return 8;
            7'h73: if (w == 32'h0000_0073 || w == 32'h0010_0073) return 9;
            7'h7F: return 10;
            default: return 0;
        endcase
        return 0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 11))
            0: w[6:0] = 7'h33;   1: w[6:0] = 7'h13;   2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h23;   4: w[6:0] = 7'h63;   5: w[6:0] = 7'h6F;
            6: w[6:0] = 7'h37;   7: w[6:0] = 7'h17;   8: w[6:0] = 7'h73;
            9: w[6:0] = 7'h7F;  10: w[6:0] = 7'h67;  default: ;
        endcase
        w[11:7]  = 5'($urandom_range(0, 18));
        w[19:15] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 18));
        w[24:20] = 5'($urandom_range(0, 18));
        case ($urandom_range(0, 3))
            0, 1: w[31:25] = 7'h00;
            2:    w[31:25] = 7'h20;
            default: ;
        endcase
        if (w[6:0] == 7'h03 && $urandom_range(0, 3) != 0) w[31:20] = 12'($urandom_range(0, 70));
        if (w[6:0] == 7'h23) w[31:25] = 7'($urandom_range(0, 3));
        if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 0)
            w = ($urandom_range(0, 1) == 0) ? 32'h0000_0073 : 32'h0010_0073;
        return w;
    endfunction

    task automatic check_regs(input string tag);
        check({tag, "_phase"}, 32'(phase), m_ph);
        check({tag, "_cnt"}, 32'(issue_cnt), m_cnt);
        check({tag, "_viol"}, 32'(violation), 32'(m_viol));
        check({tag, "_vinstr"}, viol_instr, m_vw);
    endtask

    task automatic step(input bit v, input logic [31:0] w, input bit c);
        logic [31:0] cls;
        bit          ml;
        @(negedge clk);
        instr_valid = v; instruction = w; sif_commit = c;
        #2;
        cls = ref_class(w);
        ml  = !v || (cls != 0 && (m_ph == 2 || (cls != 4 && (m_cnt < 8 || cls == 10))));
        obs_legal = legal;
        check("legal", 32'(legal), 32'(ml));
        check("class", 32'(inst_class), cls);
        @(posedge clk);
        if (v && ml && cls != 10 && m_ph != 2 && m_cnt < 8) m_cnt++;
        if (v && !ml && !m_viol) begin m_viol = 1'b1; m_vw = w; end
        if (m_ph == 0) m_ph = c ? 2 : (v ? 1 : 0);
        else if (m_ph == 1 && c) m_ph = 2;
        #1;
        check_regs("step");
    endtask

    // Asserted mid-cycle, away from any clock edge, so only the async path can act
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1; instr_valid = 1'b0; sif_commit = 1'b0;
        m_ph = 0; m_cnt = 0; m_viol = 1'b0; m_vw = '0;
        #1;
        check_regs("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instruction = '0; sif_commit = 1'b0;
        m_ph = 0; m_cnt = 0; m_viol = 1'b0; m_vw = '0;
        repeat (2) @(negedge clk);
        check_regs("init");
        rst = 1'b0;

        step(1'b1, 32'h003100B3, 1'b0);
        check("p1_legal", 32'(obs_legal), 32'd1);
        check("p1_phase", 32'(phase), 32'd1);
        check("p1_cnt", 32'(issue_cnt), 32'd1);

        step(1'b1, 32'h00202223, 1'b0);
        check("p2_legal", 32'(obs_legal), 32'd0);
        check("p2_vinstr", viol_instr, 32'h00202223);
        step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h00202223, 1'b0);
        check("p2_post_legal", 32'(obs_legal), 32'd1);

        step(1'b1, 32'h003108B3, 1'b0);
        check("p3_rd17", 32'(obs_legal), 32'd0);
        step(1'b1, 32'h04002083, 1'b0);
        check("p3_lw64", 32'(obs_legal), 32'd0);
        step(1'b1, 32'h03C02083, 1'b0);
        check("p3_lw60", 32'(obs_legal), 32'd1);

        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 32'h00108093, 1'b0);
        check("p4_cnt8", 32'(issue_cnt), 32'd8);
        step(1'b1, 32'h00108093, 1'b0);
        check("p4_over", 32'(obs_legal), 32'd0);
        check("p4_hold", 32'(issue_cnt), 32'd8);
        step(1'b1, 32'h0000007F, 1'b0);
        check("p4_nop", 32'(obs_legal), 32'd1);

        step(1'b1, 32'h00202223, 1'b1);
        check("p5_same", 32'(obs_legal), 32'd0);
        step(1'b1, 32'h00202223, 1'b0);
        check("p5_next", 32'(obs_legal), 32'd1);
        check("p5_phase", 32'(phase), 32'd2);

        do_reset();
        step(1'b1, 32'h003100B3, 1'b0);
        step(1'b1, 32'hFFFF_FFFF & 32'h00000067, 1'b0);
        check("p6_viol", 32'(violation), 32'd1);
        do_reset();
        step(1'b1, 32'h008000EF, 1'b0);
        check("p6_jal", 32'(obs_legal), 32'd0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            step($urandom_range(0, 4) != 0, rand_instr(), $urandom_range(0, 39) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
